// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for the instruction fetch queue
interface fetch_queue_if #(
  parameter int N     = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_pc;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_pc;
  logic [31:0]   out_instr;
  logic [CW-1:0] count;

  // Queue side
  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );

  // Fetch/decode side
  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular-buffer instruction fetch queue between fetch and decode
module fetch_queue #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  pc_mem   [DEPTH];
  logic [31:0]   instr_mem[DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          push;
  logic          pop;
  logic          wr_en;

  // Ready/valid come only from registered occupancy; no in->out path.
  assign bus.in_ready  = (count_q != CW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;
  assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr_q]    : '0;
  assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr_q] : '0;

  assign push  = bus.in_valid  && bus.in_ready;
  assign pop   = bus.out_valid && bus.out_ready;
  assign wr_en = reset && !bus.flush && push;

  // Next-state for pointers and occupancy; flush wipes everything and drops the push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Control state with synchronous active-low reset taking priority over flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care after reset so it is not cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= bus.in_pc;
      instr_mem[wr_ptr_q] <= bus.in_instr;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;
  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.N(N), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] pc;
    int          exp_count;
    logic        exp_ov;
    logic        exp_ir;
    logic [63:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  vec_t   vecs[$];
  entry_t model[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tag_instr(input logic [63:0] pc);
    return 32'h8B00_0000 | pc[23:0];
  endfunction

  task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [63:0] pc, input logic [31:0] ins);
    reset         = r;
    bus.flush     = f;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int c, input logic ov, input logic ir,
                             input logic [63:0] pc, input logic [31:0] ins);
    check({tag, ".count"},     64'(bus.count),     64'(c));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
    check({tag, ".in_ready"},  64'(bus.in_ready),  64'(ir));
    check({tag, ".out_pc"},    bus.out_pc,         pc);
    check({tag, ".out_instr"}, 64'(bus.out_instr), 64'(ins));
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic ordy,
                              input logic [63:0] pc, input int c, input logic ov,
                              input logic ir, input logic [63:0] epc);
    vec_t v;
    v.rst_n = r; v.flush = f; v.in_valid = iv; v.out_ready = ordy; v.pc = pc;
    v.exp_count = c; v.exp_ov = ov; v.exp_ir = ir; v.exp_pc = epc;
    return v;
  endfunction

  initial begin
    logic [63:0] rpc;
    logic [31:0] rins;
    logic        rr, rf, riv, ror, m_ir, m_ov;
    entry_t      e;

    reset = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_pc = '0; bus.in_instr = '0;

    // reset with a push pending
    vecs.push_back(mk(0, 0, 1, 0, 64'h40, 0, 0, 1, 64'h0));
    vecs.push_back(mk(0, 0, 1, 0, 64'h40, 0, 0, 1, 64'h0));
    // fill to full, then a rejected fifth push
    vecs.push_back(mk(1, 0, 1, 0, 64'h00, 1, 1, 1, 64'h00));
    vecs.push_back(mk(1, 0, 1, 0, 64'h04, 2, 1, 1, 64'h00));
    vecs.push_back(mk(1, 0, 1, 0, 64'h08, 3, 1, 1, 64'h00));
    vecs.push_back(mk(1, 0, 1, 0, 64'h0C, 4, 1, 0, 64'h00));
    vecs.push_back(mk(1, 0, 1, 0, 64'h10, 4, 1, 0, 64'h00));
    // drain, then pop on empty must not underflow
    vecs.push_back(mk(1, 0, 0, 1, 64'h0, 3, 1, 1, 64'h04));
    vecs.push_back(mk(1, 0, 0, 1, 64'h0, 2, 1, 1, 64'h08));
    vecs.push_back(mk(1, 0, 0, 1, 64'h0, 1, 1, 1, 64'h0C));
    vecs.push_back(mk(1, 0, 0, 1, 64'h0, 0, 0, 1, 64'h00));
    vecs.push_back(mk(1, 0, 0, 1, 64'h0, 0, 0, 1, 64'h00));
    // full with simultaneous pop: push of 0x30 is dropped
    vecs.push_back(mk(1, 0, 1, 0, 64'h20, 1, 1, 1, 64'h20));
    vecs.push_back(mk(1, 0, 1, 0, 64'h24, 2, 1, 1, 64'h20));
    vecs.push_back(mk(1, 0, 1, 0, 64'h28, 3, 1, 1, 64'h20));
    vecs.push_back(mk(1, 0, 1, 0, 64'h2C, 4, 1, 0, 64'h20));
    vecs.push_back(mk(1, 0, 1, 1, 64'h30, 3, 1, 1, 64'h24));
    vecs.push_back(mk(1, 0, 0, 1, 64'h0, 2, 1, 1, 64'h28));
    vecs.push_back(mk(1, 0, 0, 1, 64'h0, 1, 1, 1, 64'h2C));
    vecs.push_back(mk(1, 0, 0, 1, 64'h0, 0, 0, 1, 64'h00));
    // flush with concurrent push and pop
    vecs.push_back(mk(1, 0, 1, 0, 64'h40, 1, 1, 1, 64'h40));
    vecs.push_back(mk(1, 0, 1, 0, 64'h44, 2, 1, 1, 64'h40));
    vecs.push_back(mk(1, 0, 1, 0, 64'h48, 3, 1, 1, 64'h40));
    vecs.push_back(mk(1, 1, 1, 1, 64'h200, 0, 0, 1, 64'h00));
    vecs.push_back(mk(1, 0, 1, 0, 64'h300, 1, 1, 1, 64'h300));
    vecs.push_back(mk(1, 0, 0, 1, 64'h0, 0, 0, 1, 64'h00));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready,
            vecs[i].pc, tag_instr(vecs[i].pc));
      check_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_ov, vecs[i].exp_ir,
                  vecs[i].exp_pc, vecs[i].exp_ov ? tag_instr(vecs[i].exp_pc) : 32'h0);
    end

    // streaming across pointer wrap: count holds at 1, each entry shows one cycle after push
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, (i != 0), 64'h100 + 64'(4 * i), 32'h8B00_0000 + 32'(i));
      check_state($sformatf("stream%0d", i), 1, 1, 1, 64'h100 + 64'(4 * i),
                  32'h8B00_0000 + 32'(i));
    end
    drive(1, 0, 0, 1, 64'h0, 32'h0);
    check_state("stream_end", 0, 0, 1, 64'h0, 32'h0);

    // reset while busy, reset wins over the concurrent push
    drive(1, 0, 1, 0, 64'h400, 32'h1);
    drive(1, 0, 1, 0, 64'h404, 32'h2);
    check("busy.count", 64'(bus.count), 64'd2);
    drive(0, 0, 1, 1, 64'h4FF, 32'h3);
    check_state("busy_rst", 0, 0, 1, 64'h0, 32'h0);
    drive(1, 0, 1, 0, 64'h500, 32'h5);
    check_state("after_rst", 1, 1, 1, 64'h500, 32'h5);
    drive(1, 0, 0, 1, 64'h0, 32'h0);
    check_state("after_rst_pop", 0, 0, 1, 64'h0, 32'h0);

    // randomized traffic against a queue-based reference
    model.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rr   = ($urandom_range(0, 99) >= 2);
      rf   = ($urandom_range(0, 99) < 5);
      riv  = ($urandom_range(0, 99) < 60);
      ror  = ($urandom_range(0, 99) < 50);
      rpc  = {$urandom, $urandom};
      rins = $urandom;
      m_ir = (model.size() != DEPTH);
      m_ov = (model.size() != 0);
      drive(rr, rf, riv, ror, rpc, rins);
      if (!rr || rf) begin
        model.delete();
      end else begin
        if (m_ov && ror) void'(model.pop_front());
        if (m_ir && riv) begin
          e.pc = rpc; e.instr = rins;
          model.push_back(e);
        end
      end
      if (model.size() != 0)
        check_state($sformatf("rnd%0d", cyc), model.size(), 1, model.size() != DEPTH,
                    model[0].pc, model[0].instr);
      else
        check_state($sformatf("rnd%0d", cyc), 0, 0, 1, 64'h0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
